tt_um_sunaofurukawa_cpu_rf: RTL
===============================

# tt_um_sunaofurukawa_cpu_rf

Parametrised successor to the team's 8-bit accumulator CPU. It replaces the single accumulator with an NREG-entry register file and adds a DATA_W-wide datapath, zero/carry flags, a valid/ready instruction handshake, an explicit OUT instruction, and a multi-cycle serial multiply. It sits between the host instruction feed and the user output pins.

## Interface
- DATA_W, 8: datapath and register width; ≥4.
- NREG, 4: register count; power of two, ≥2. RW = $clog2(NREG).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- ena  in  1  global enable. Low: all state frozen, instr_ready = 0.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  instruction accepted on edge where valid & ready.
- op  in  4  opcode.
- rd  in  RW  destination/first-source register.
- rs  in  RW  register source.
- src_sel  in  1  0: B = imm, 1: B = reg[rs].
- imm  in  DATA_W  immediate.
- out_data  out  DATA_W  last OUT result.
- out_valid  out  1  one-cycle pulse when out_data updates.
- flag_z  out  1  zero flag.
- flag_c  out  1  carry/borrow flag.

## Operation
- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 NOT, 6 XOR, 7 SHL, 8 SHR, 9 LDI, A MUL, B OUT. Codes C–F act as NOP.
- A = reg[rd]. Result R is written to rd for every op except NOP and OUT.
- ADD: {C,R} = A + B. SUB: R = A − B, C = borrow (A < B unsigned).
- AND/OR/XOR: bitwise with B. NOT: R = ~A, B ignored. SHL/SHR: shift by 1 (B ignored), C = the bit shifted out.
- LDI: R = B. C unchanged.
- MUL: unsigned A×B. R = low DATA_W bits. C = 1 iff high half ≠ 0.
- Z = (R == 0) for every op that writes R. C is unchanged for AND, OR, XOR, NOT and LDI. Flags are unchanged for NOP and OUT.
- OUT: out_data ← reg[rd] and out_valid pulses. Registers and flags unchanged.
- Pipeline stages:
  - S1 (fetch latch): holds one accepted instruction.
  - S2 (execute): reads the register file at execute time, so there are no data hazards. Back-to-back dependent instructions are correct.
- Execute FSM:
  - EXEC: single-cycle ops.
  - MUL_BUSY: shift-add over DATA_W cycles, then writes back and returns to EXEC.
- instr_ready = ena & (!s1_valid | (state == EXEC & s1 not MUL-in-progress)). This is the standard skid-free single-entry rule: S1 may refill on the edge it drains.

## Timing
- Reset: all registers 0, flag_z = 0, flag_c = 0, out_data = 0, out_valid = 0, S1 empty, state = EXEC. instr_ready = 0 while rst_n is low.
- Single-cycle op accepted at edge N: executes at edge N+1; register and flags are visible after N+1. OUT accepted at N: out_valid is high during cycle N+1 → N+2.
- MUL accepted at N: enters MUL_BUSY at N+1, writes back at edge N+1+DATA_W. instr_ready is low from the cycle S1 refills until MUL completes. Peak throughput is one instruction per cycle.
- valid held with ready low: instruction is held by the source, not lost, and accepted exactly once.
- ena low mid-MUL: the iteration counter freezes and resumes without error.
- rst_n asserted mid-MUL or with S1 full: immediate abort, all reset values, the pending instruction is discarded.
- Simultaneous S2 write to rd and OUT of the same rd in S1: OUT executes next cycle and sees the new value.

## Structure
- Shared package tt_um_sunaofurukawa_cpu_pkg holds the opcode localparams and the FSM state encoding (EXEC, MUL_BUSY).
- Sub-module tt_um_sunaofurukawa_cpu_mul_serial (start, a, b → busy, done, product[2*DATA_W-1:0]; DATA_W-cycle shift-add).
- Register file, S1 latch and ALU live in the top module.

## Test plan
- Reset, then LDI r0,200; ADD r0,imm 100; OUT r0 → out_data = 44, flag_c = 1, flag_z = 0, out_valid a single pulse.
- LDI r1,5; SUB r1,imm 6 → r1 = 255, flag_c = 1; then SUB r1,imm 255 → r1 = 0, flag_z = 1, flag_c = 0.
- LDI r2,20; LDI r3,13; MUL r2,src_sel = 1, rs = r3 → r2 = 4, flag_c = 1 after 8 busy cycles. instr_ready stays low while a following OUT waits; OUT r2 then gives 4.
- Continuous valid with random ready/ena toggling over 200 random instructions → register, flag and out_data trace matches the golden model; no instruction is dropped or duplicated.
- rst_n pulsed low on cycle 3 of a MUL → all outputs 0, registers 0; the next LDI/OUT works normally.
- SHL on 0x80 → R = 0, flag_c = 1, flag_z = 1. SHR on 0x01 → R = 0, flag_c = 1. Opcode 0xE → no state change.

Source files
------------

// File: rtl/tt_um_sunaofurukawa_cpu_pkg.sv
// Opcodes and execute-FSM encoding shared by the register-file CPU and its multiplier.
package tt_um_sunaofurukawa_cpu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_SHL = 4'h7;
  localparam logic [3:0] OP_SHR = 4'h8;
  localparam logic [3:0] OP_LDI = 4'h9;
  localparam logic [3:0] OP_MUL = 4'hA;
  localparam logic [3:0] OP_OUT = 4'hB;

  typedef enum logic {
    EXEC     = 1'b0,
    MUL_BUSY = 1'b1
  } exec_state_e;

endpackage

// File: rtl/tt_um_sunaofurukawa_cpu_rf_if.sv
// Instruction feed and result pins between the host and the register-file CPU.
interface tt_um_sunaofurukawa_cpu_rf_if #(
  parameter int DATA_W = 8,
  parameter int NREG   = 4
);
  localparam int RW = $clog2(NREG);

  logic              instr_valid;
  logic              instr_ready;
  logic [3:0]        op;
  logic [RW-1:0]     rd;
  logic [RW-1:0]     rs;
  logic              src_sel;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              flag_z;
  logic              flag_c;

  modport master (
    output instr_valid, op, rd, rs, src_sel, imm,
    input  instr_ready, out_data, out_valid, flag_z, flag_c
  );

  modport slave (
    input  instr_valid, op, rd, rs, src_sel, imm,
    output instr_ready, out_data, out_valid, flag_z, flag_c
  );
endinterface

// File: rtl/tt_um_sunaofurukawa_cpu_mul_serial.sv
// Unsigned shift-add multiplier: one multiplier bit per enabled cycle, DATA_W cycles total.
module tt_um_sunaofurukawa_cpu_mul_serial #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                start,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic                busy,
  output logic                done,
  output logic [2*DATA_W-1:0] product
);
  localparam int CW = $clog2(DATA_W + 1);

  logic [2*DATA_W-1:0] acc;
  logic [2*DATA_W-1:0] mcand;
  logic [DATA_W-1:0]   mplier;
  logic [CW-1:0]       cnt;
  logic [2*DATA_W-1:0] acc_next;

  assign acc_next = acc + (mplier[0] ? mcand : '0);
  // product is valid combinationally during the final iteration so the
  // caller can write back on the same edge that retires it
  assign done     = busy & (cnt == CW'(1));
  assign product  = acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (en) begin
      if (start && !busy) begin
        acc    <= '0;
        mcand  <= {{DATA_W{1'b0}}, a};
        mplier <= b;
        cnt    <= CW'(DATA_W);
        busy   <= 1'b1;
      end else if (busy) begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CW'(1);
        if (cnt == CW'(1)) busy <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/tt_um_sunaofurukawa_cpu_rf.sv
// Register-file CPU: single-entry fetch latch (S1) feeding an execute stage with a serial multiply.
//   state    | meaning
//   EXEC     | S1 instruction executes this cycle (single-cycle ops, MUL launch)
//   MUL_BUSY | multiplier iterating; S1 holds, writeback on the final iteration
module tt_um_sunaofurukawa_cpu_rf
  import tt_um_sunaofurukawa_cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREG   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  tt_um_sunaofurukawa_cpu_rf_if.slave bus
);
  localparam int RW = $clog2(NREG);

  logic [DATA_W-1:0] regs [NREG];
  logic              s1_valid;
  logic [3:0]        s1_op;
  logic [RW-1:0]     s1_rd;
  logic [RW-1:0]     s1_rs;
  logic              s1_src_sel;
  logic [DATA_W-1:0] s1_imm;
  exec_state_e       state, state_next;
  logic [RW-1:0]     mul_rd;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q, flag_z_q, flag_c_q;

  logic              accept, exec_fire, mul_wb;
  logic [DATA_W-1:0] op_a, op_b, alu_r, wr_data;
  logic              alu_c, alu_wr, alu_c_en, is_mul, is_out;
  logic              wr_en, c_en, c_next;
  logic [RW-1:0]     wr_addr;
  logic              mul_busy, mul_done;
  logic [2*DATA_W-1:0] mul_product;

  assign bus.instr_ready = rst_n & ena & (!s1_valid | (state == EXEC & !mul_busy));
  assign accept          = bus.instr_valid & bus.instr_ready;
  assign exec_fire       = ena & s1_valid & (state == EXEC);
  assign mul_wb          = ena & (state == MUL_BUSY) & mul_done;
  assign op_a            = regs[s1_rd];
  assign op_b            = s1_src_sel ? regs[s1_rs] : s1_imm;

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.flag_z    = flag_z_q;
  assign bus.flag_c    = flag_c_q;

  tt_um_sunaofurukawa_cpu_mul_serial #(.DATA_W(DATA_W)) u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (ena),
    .start  (exec_fire & is_mul),
    .a      (op_a),
    .b      (op_b),
    .busy   (mul_busy),
    .done   (mul_done),
    .product(mul_product)
  );

  always_comb begin
    alu_r    = '0;
    alu_c    = flag_c_q;
    alu_wr   = 1'b0;
    alu_c_en = 1'b0;
    is_mul   = 1'b0;
    is_out   = 1'b0;
    case (s1_op)
      OP_ADD: begin {alu_c, alu_r} = {1'b0, op_a} + {1'b0, op_b}; alu_wr = 1'b1; alu_c_en = 1'b1; end
      OP_SUB: begin {alu_c, alu_r} = {1'b0, op_a} - {1'b0, op_b}; alu_wr = 1'b1; alu_c_en = 1'b1; end
      OP_AND: begin alu_r = op_a & op_b; alu_wr = 1'b1; end
      OP_OR:  begin alu_r = op_a | op_b; alu_wr = 1'b1; end
      OP_NOT: begin alu_r = ~op_a;       alu_wr = 1'b1; end
      OP_XOR: begin alu_r = op_a ^ op_b; alu_wr = 1'b1; end
      OP_SHL: begin alu_r = {op_a[DATA_W-2:0], 1'b0}; alu_c = op_a[DATA_W-1]; alu_wr = 1'b1; alu_c_en = 1'b1; end
      OP_SHR: begin alu_r = {1'b0, op_a[DATA_W-1:1]}; alu_c = op_a[0];        alu_wr = 1'b1; alu_c_en = 1'b1; end
      OP_LDI: begin alu_r = op_b; alu_wr = 1'b1; end
      OP_MUL: is_mul = 1'b1;
      OP_OUT: is_out = 1'b1;
      default: ;
    endcase
  end

  // MUL writeback and S1 execution are exclusive: S1 only executes in EXEC
  always_comb begin
    wr_en   = 1'b0;
    wr_data = alu_r;
    wr_addr = s1_rd;
    c_en    = 1'b0;
    c_next  = alu_c;
    if (mul_wb) begin
      wr_en   = 1'b1;
      wr_data = mul_product[DATA_W-1:0];
      wr_addr = mul_rd;
      c_en    = 1'b1;
      c_next  = |mul_product[2*DATA_W-1:DATA_W];
    end else if (exec_fire) begin
      wr_en = alu_wr;
      c_en  = alu_c_en;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      EXEC:     if (exec_fire & is_mul) state_next = MUL_BUSY;
      MUL_BUSY: if (mul_wb)             state_next = EXEC;
      default:                          state_next = EXEC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EXEC;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      s1_valid    <= 1'b0;
      s1_op       <= OP_NOP;
      s1_rd       <= '0;
      s1_rs       <= '0;
      s1_src_sel  <= 1'b0;
      s1_imm      <= '0;
      mul_rd      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      flag_z_q    <= 1'b0;
      flag_c_q    <= 1'b0;
    end else begin
      // a pulse, not held state: it drops even while ena is low
      out_valid_q <= exec_fire & is_out;
      if (ena) begin
        if (accept) begin
          s1_valid   <= 1'b1;
          s1_op      <= bus.op;
          s1_rd      <= bus.rd;
          s1_rs      <= bus.rs;
          s1_src_sel <= bus.src_sel;
          s1_imm     <= bus.imm;
        end else if (exec_fire) begin
          s1_valid <= 1'b0;
        end
        if (wr_en) begin
          regs[wr_addr] <= wr_data;
          flag_z_q      <= (wr_data == '0);
        end
        if (c_en) flag_c_q <= c_next;
        if (exec_fire & is_mul) mul_rd <= s1_rd;
        if (exec_fire & is_out) out_data_q <= op_a;
      end
    end
  end
endmodule
